// File: rtl/out_pixel_packer.sv
// out_pixel_packer: gathers up to four byte-wide pixel writes per cycle into 32-bit words
// and queues them in a small FIFO feeding a wide output memory.
module out_pixel_packer #(
    parameter int AW         = 18,
    parameter int OUT_BASE   = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_mode_simd,
    input  logic [AW-1:0] i_waddr0,
    input  logic [AW-1:0] i_waddr1,
    input  logic [AW-1:0] i_waddr2,
    input  logic [AW-1:0] i_waddr3,
    input  logic [7:0]    i_wdata0,
    input  logic [7:0]    i_wdata1,
    input  logic [7:0]    i_wdata2,
    input  logic [7:0]    i_wdata3,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic          i_we2,
    input  logic          i_we3,
    input  logic          i_flush,
    output logic          req_valid,
    input  logic          req_ready,
    output logic          req_we,
    output logic [AW-1:0] req_addr,
    output logic [31:0]   req_wdata,
    output logic [3:0]    req_be,
    output logic          o_idle,
    output logic [31:0]   o_word_count,
    output logic          o_err_overflow,
    output logic          o_err_scatter
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
    } word_t;

    logic [AW-1:0] waddr [4];
    logic [7:0]    wdata [4];
    logic [3:0]    act;
    word_t         mem [FIFO_DEPTH];
    word_t         buf_q, word_a, word_b, slot0;
    logic          buf_valid, flush_pend, any, hit, flush_now, push_old, push_a, scatter, pop;
    logic [AW-1:0] a_addr;
    logic [1:0]    n_push, n_acc;
    logic [PW:0]   count, space;
    logic [PW-1:0] rptr, wptr;

    assign waddr[0] = i_waddr0;
    assign waddr[1] = i_waddr1;
    assign waddr[2] = i_waddr2;
    assign waddr[3] = i_waddr3;
    assign wdata[0] = i_wdata0;
    assign wdata[1] = i_wdata1;
    assign wdata[2] = i_wdata2;
    assign wdata[3] = i_wdata3;
    assign act = {i_we3 & i_mode_simd, i_we2 & i_mode_simd, i_we1 & i_mode_simd, i_we0};
    assign any = |act;

    always_comb begin
        a_addr  = '0;
        word_a  = '0;
        word_b  = '0;
        scatter = 1'b0;
        for (int k = 3; k >= 0; k--)
            if (act[k]) a_addr = waddr[k] >> 2;
        word_a.addr = a_addr;
        word_b.addr = a_addr + AW'(1);
        // ascending lane order lets the higher lane win a shared byte
        for (int k = 0; k < 4; k++) begin
            if (act[k] && (waddr[k] >> 2) == word_a.addr) begin
                word_a.data[{waddr[k][1:0], 3'b000} +: 8] = wdata[k];
                word_a.be[waddr[k][1:0]] = 1'b1;
            end else if (act[k] && (waddr[k] >> 2) == word_b.addr) begin
                word_b.data[{waddr[k][1:0], 3'b000} +: 8] = wdata[k];
                word_b.be[waddr[k][1:0]] = 1'b1;
            end else if (act[k]) begin
                scatter = 1'b1;
            end
        end
        hit = buf_valid && buf_q.addr == a_addr;
        for (int b = 0; b < 4; b++)
            if (hit && !word_a.be[b]) word_a.data[8*b +: 8] = buf_q.data[8*b +: 8];
        word_a.be = word_a.be | (hit ? buf_q.be : 4'h0);
        flush_now = !any && (i_flush || flush_pend);
        push_old  = buf_valid && (any ? !hit : flush_now);
        push_a    = any && (word_b.be != 4'h0 || word_a.be == 4'hF);
        slot0     = push_old ? buf_q : word_a;
        n_push    = {1'b0, push_old} + {1'b0, push_a};
    end

    // free space counts the entry vacated by a same-cycle pop
    assign pop   = req_valid && req_ready;
    assign space = (PW+1)'(FIFO_DEPTH) - count + {{PW{1'b0}}, pop};
    assign n_acc = ({{(PW-1){1'b0}}, n_push} > space) ? space[1:0] : n_push;
    assign wptr  = rptr + count[PW-1:0];

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid      <= 1'b0;
            buf_q          <= '0;
            flush_pend     <= 1'b0;
            count          <= '0;
            rptr           <= '0;
            o_word_count   <= '0;
            o_err_overflow <= 1'b0;
            o_err_scatter  <= 1'b0;
        end else if (i_start) begin
            buf_valid      <= 1'b0;
            buf_q          <= '0;
            flush_pend     <= 1'b0;
            count          <= '0;
            rptr           <= '0;
            o_word_count   <= '0;
            o_err_overflow <= 1'b0;
            o_err_scatter  <= 1'b0;
        end else begin
            if (any) begin
                buf_valid <= word_b.be != 4'h0 || word_a.be != 4'hF;
                buf_q     <= (word_b.be != 4'h0) ? word_b : word_a;
            end else if (flush_now) begin
                buf_valid <= 1'b0;
            end
            flush_pend     <= any && (i_flush || flush_pend);
            count          <= count + {{(PW-1){1'b0}}, n_acc} - {{PW{1'b0}}, pop};
            rptr           <= rptr + {{(PW-1){1'b0}}, pop};
            o_word_count   <= o_word_count + {31'd0, pop};
            o_err_overflow <= o_err_overflow || n_acc != n_push;
            o_err_scatter  <= o_err_scatter || scatter;
        end
    end

    always_ff @(posedge clk_50) begin
        if (n_acc != 2'd0) mem[wptr] <= slot0;
        if (n_acc == 2'd2) mem[wptr + PW'(1)] <= word_a;
    end

    assign req_valid = count != '0;
    assign req_we    = 1'b1;
    assign req_addr  = req_valid ? mem[rptr].addr + AW'(OUT_BASE) : '0;
    assign req_wdata = req_valid ? mem[rptr].data : '0;
    assign req_be    = req_valid ? mem[rptr].be : '0;
    assign o_idle    = !buf_valid && !req_valid && !flush_pend;
endmodule

// File: tb/tb_out_pixel_packer.sv
// tb_out_pixel_packer: directed and randomized checks of out_pixel_packer against a
// byte-level reference model of the packing rules kept in a queue of words.
module tb_out_pixel_packer;
    localparam int AW    = 18;
    localparam int BASE  = 'h100;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
    } mword_t;

    logic          clk_50 = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_mode_simd = 1'b0;
    logic          i_flush = 1'b0, req_ready = 1'b0;
    logic [AW-1:0] wa [4];
    logic [7:0]    wd [4];
    logic [3:0]    we = 4'h0;
    logic          req_valid, req_we, o_idle, o_err_overflow, o_err_scatter;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata, o_word_count;
    logic [3:0]    req_be;
    int            errors = 0, checks = 0;

    mword_t      m_q[$];
    mword_t      m_buf;
    bit          m_bv, m_fp, m_ovf, m_sct;
    int unsigned m_cnt;

    out_pixel_packer #(.AW(AW), .OUT_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .i_start(i_start), .i_mode_simd(i_mode_simd),
        .i_waddr0(wa[0]), .i_waddr1(wa[1]), .i_waddr2(wa[2]), .i_waddr3(wa[3]),
        .i_wdata0(wd[0]), .i_wdata1(wd[1]), .i_wdata2(wd[2]), .i_wdata3(wd[3]),
        .i_we0(we[0]), .i_we1(we[1]), .i_we2(we[2]), .i_we3(we[3]),
        .i_flush(i_flush), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .o_idle(o_idle),
        .o_word_count(o_word_count), .o_err_overflow(o_err_overflow),
        .o_err_scatter(o_err_scatter)
    );

    always #10 clk_50 = ~clk_50;

    function automatic void m_clear();
        m_q.delete();
        m_buf = '0;
        m_bv  = 0;
        m_fp  = 0;
        m_ovf = 0;
        m_sct = 0;
        m_cnt = 0;
    endfunction

    function automatic void m_push(mword_t w);
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_ovf = 1;
    endfunction

    // one clock edge of the model, using the inputs present at that edge
    function automatic void m_edge();
        mword_t wa_w, wb_w;
        logic [3:0] lanes;
        int a, d, b;
        if (i_start) begin
            m_clear();
            return;
        end
        if (m_q.size() != 0 && req_ready) begin
            void'(m_q.pop_front());
            m_cnt++;
        end
        lanes = i_mode_simd ? we : {3'b000, we[0]};
        if (lanes == 4'h0) begin
            if (i_flush || m_fp) begin
                if (m_bv) m_push(m_buf);
                m_bv = 0;
                m_fp = 0;
            end
            return;
        end
        m_fp = m_fp | i_flush;
        a = -1;
        for (int k = 0; k < 4; k++)
            if (lanes[k] && a < 0) a = int'(wa[k]) / 4;
        if (m_bv && int'(m_buf.addr) != a) begin
            m_push(m_buf);
            m_bv = 0;
        end
        if (m_bv) wa_w = m_buf;
        else begin
            wa_w = '0;
            wa_w.addr = AW'(a);
        end
        wb_w = '0;
        wb_w.addr = AW'(a + 1);
        for (int k = 0; k < 4; k++) begin
            if (lanes[k]) begin
                d = int'(wa[k]) / 4 - a;
                b = int'(wa[k]) % 4;
                if (d == 0) begin
                    wa_w.data[8*b +: 8] = wd[k];
                    wa_w.be[b] = 1'b1;
                end else if (d == 1) begin
                    wb_w.data[8*b +: 8] = wd[k];
                    wb_w.be[b] = 1'b1;
                end else m_sct = 1;
            end
        end
        if (wb_w.be != 4'h0) begin
            m_push(wa_w);
            m_buf = wb_w;
            m_bv  = 1;
        end else if (wa_w.be == 4'hF) begin
            m_push(wa_w);
            m_bv = 0;
        end else begin
            m_buf = wa_w;
            m_bv  = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk_50);
        m_edge();
        #1;
    endtask

    task automatic drive_idle();
        i_start = 0;
        i_flush = 0;
        we = 4'h0;
        for (int k = 0; k < 4; k++) begin
            wa[k] = '0;
            wd[k] = '0;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        #5;
        checks++;
        if (req_valid !== 1'b0 || req_addr !== '0 || req_wdata !== 32'h0 || req_be !== 4'h0) begin
            errors++;
            $display("FAIL reset_req: valid=%b addr=%h data=%h be=%h, want all zero", req_valid, req_addr, req_wdata, req_be);
        end
        checks++;
        if (o_idle !== 1'b1 || o_word_count !== 32'h0 || o_err_overflow !== 1'b0 || o_err_scatter !== 1'b0 || req_we !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: idle=%b count=%0d ovf=%b sct=%b we=%b, want 1 0 0 0 1", o_idle, o_word_count, o_err_overflow, o_err_scatter, req_we);
        end
        @(negedge clk_50);
        rst_n = 1;
        m_clear();
        tick();
        checks++;
        if (req_we !== 1'b1 || req_valid !== 1'b0 || o_idle !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: we=%b valid=%b idle=%b, want 1 0 1", req_we, req_valid, o_idle);
        end
    endtask

    task automatic test_seq_pack();
        req_ready = 1;
        i_mode_simd = 0;
        for (int i = 0; i < 4; i++) begin
            we[0] = 1;
            wa[0] = AW'(i);
            wd[0] = 8'(10 * (i + 1));
            tick();
            if (i == 2) begin
                checks++;
                if (req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_partial: valid=%b, want 0", req_valid);
                end
            end
        end
        drive_idle();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== AW'(BASE) || req_wdata !== 32'h281E140A || req_be !== 4'hF) begin
            errors++;
            $display("FAIL seq_word: valid=%b addr=%h data=%h be=%h, want 1 %h 281e140a f", req_valid, req_addr, req_wdata, req_be, AW'(BASE));
        end
        tick();
        checks++;
        if (o_word_count !== 32'd1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_count: count=%0d valid=%b, want 1 0", o_word_count, req_valid);
        end
    endtask

    task automatic test_simd_flush();
        req_ready = 0;
        i_mode_simd = 1;
        we = 4'hF;
        for (int k = 0; k < 4; k++) begin
            wa[k] = AW'(6 + k);
            wd[k] = 8'(k + 1);
        end
        tick();
        drive_idle();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== AW'(BASE + 1) || req_wdata !== 32'h02010000 || req_be !== 4'hC || o_idle !== 1'b0) begin
            errors++;
            $display("FAIL simd_word1: valid=%b addr=%h data=%h be=%h idle=%b, want 1 %h 02010000 c 0", req_valid, req_addr, req_wdata, req_be, o_idle, AW'(BASE + 1));
        end
        i_flush = 1;
        tick();
        i_flush = 0;
        req_ready = 1;
        tick();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== AW'(BASE + 2) || req_wdata !== 32'h00000403 || req_be !== 4'h3) begin
            errors++;
            $display("FAIL simd_word2: valid=%b addr=%h data=%h be=%h, want 1 %h 00000403 3", req_valid, req_addr, req_wdata, req_be, AW'(BASE + 2));
        end
        tick();
        checks++;
        if (req_valid !== 1'b0 || o_idle !== 1'b1 || o_word_count !== 32'd3) begin
            errors++;
            $display("FAIL simd_drain: valid=%b idle=%b count=%0d, want 0 1 3", req_valid, o_idle, o_word_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        req_ready = 0;
        i_mode_simd = 1;
        for (int i = 0; i < 10; i++) begin
            we = (i < 9) ? 4'hF : 4'h0;
            for (int k = 0; k < 4; k++) begin
                wa[k] = AW'(4 * (16 + i) + k);
                wd[k] = 8'(4 * i + k + 1);
            end
            tick();
            checks++;
            if (req_valid !== 1'b1 || req_addr !== AW'(BASE + 16) || req_wdata !== 32'h04030201 || req_be !== 4'hF) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b addr=%h data=%h be=%h, want 1 %h 04030201 f", i, req_valid, req_addr, req_wdata, req_be, AW'(BASE + 16));
            end
        end
        drive_idle();
        checks++;
        if (o_err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_overflow: ovf=%b, want 1", o_err_overflow);
        end
        req_ready = 1;
        for (int j = 0; j < 8; j++) begin
            exp = {8'(4 * j + 4), 8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1)};
            checks++;
            if (req_valid !== 1'b1 || req_addr !== AW'(BASE + 16 + j) || req_wdata !== exp) begin
                errors++;
                $display("FAIL bp_drain[%0d]: valid=%b addr=%h data=%h, want 1 %h %h", j, req_valid, req_addr, req_wdata, AW'(BASE + 16 + j), exp);
            end
            tick();
        end
        checks++;
        if (req_valid !== 1'b0 || o_word_count !== 32'd11) begin
            errors++;
            $display("FAIL bp_end: valid=%b count=%0d, want 0 11", req_valid, o_word_count);
        end
    endtask

    task automatic test_scatter_start();
        i_start = 1;
        tick();
        drive_idle();
        checks++;
        if (o_err_overflow !== 1'b0 || o_err_scatter !== 1'b0 || o_word_count !== 32'd0) begin
            errors++;
            $display("FAIL start_clear: ovf=%b sct=%b count=%0d, want 0 0 0", o_err_overflow, o_err_scatter, o_word_count);
        end
        i_mode_simd = 1;
        req_ready = 0;
        we = 4'b0011;
        wa[0] = AW'(0);
        wa[1] = AW'(12);
        wd[0] = 8'h55;
        wd[1] = 8'h66;
        tick();
        drive_idle();
        i_flush = 1;
        tick();
        i_flush = 0;
        checks++;
        if (o_err_scatter !== 1'b1 || req_valid !== 1'b1 || req_addr !== AW'(BASE) || req_wdata !== 32'h00000055 || req_be !== 4'h1) begin
            errors++;
            $display("FAIL scatter: sct=%b valid=%b addr=%h data=%h be=%h, want 1 1 %h 00000055 1", o_err_scatter, req_valid, req_addr, req_wdata, req_be, AW'(BASE));
        end
        i_start = 1;
        we = 4'hF;
        for (int k = 0; k < 4; k++) wa[k] = AW'(40 + k);
        tick();
        drive_idle();
        checks++;
        if (o_err_scatter !== 1'b0 || o_idle !== 1'b1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL scatter_start: sct=%b idle=%b valid=%b, want 0 1 0", o_err_scatter, o_idle, req_valid);
        end
    endtask

    task automatic test_random();
        int base;
        i_start = 1;
        tick();
        drive_idle();
        for (int n = 0; n < 3000; n++) begin
            base = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, (1 << AW) - 8)) : int'($urandom_range(0, 40));
            i_mode_simd = $urandom_range(0, 3) != 0;
            we = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                wa[k] = ($urandom_range(0, 19) == 0) ? AW'($urandom) : AW'(base + int'($urandom_range(0, 7)));
                wd[k] = 8'($urandom);
            end
            i_flush = $urandom_range(0, 7) == 0;
            i_start = $urandom_range(0, 149) == 0;
            req_ready = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (req_valid !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid@%0d: valid=%b, want %b", n, req_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if (req_addr !== m_q[0].addr + AW'(BASE) || req_wdata !== m_q[0].data || req_be !== m_q[0].be) begin
                    errors++;
                    $display("FAIL rnd_head@%0d: addr=%h data=%h be=%h, want %h %h %h", n, req_addr, req_wdata, req_be, m_q[0].addr + AW'(BASE), m_q[0].data, m_q[0].be);
                end
            end
            checks++;
            if (o_word_count !== m_cnt || o_idle !== (!m_bv && m_q.size() == 0 && !m_fp) || o_err_overflow !== m_ovf || o_err_scatter !== m_sct) begin
                errors++;
                $display("FAIL rnd_status@%0d: count=%0d idle=%b ovf=%b sct=%b, want %0d %b %b %b", n, o_word_count, o_idle, o_err_overflow, o_err_scatter, m_cnt, !m_bv && m_q.size() == 0 && !m_fp, m_ovf, m_sct);
            end
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        i_start = 1;
        tick();
        drive_idle();
        req_ready = 1;
        i_mode_simd = 1;
        we = 4'hF;
        for (int k = 0; k < 4; k++) wa[k] = AW'(k);
        tick();
        drive_idle();
        tick();
        req_ready = 0;
        we = 4'hF;
        for (int k = 0; k < 4; k++) wa[k] = AW'(4 + k);
        tick();
        drive_idle();
        checks++;
        if (req_valid !== 1'b1 || o_word_count !== 32'd1) begin
            errors++;
            $display("FAIL areset_pre: valid=%b count=%0d, want 1 1", req_valid, o_word_count);
        end
        #4;
        rst_n = 0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || o_word_count !== 32'd0 || o_idle !== 1'b1 || req_addr !== '0 || req_we !== 1'b1) begin
            errors++;
            $display("FAIL areset: valid=%b count=%0d idle=%b addr=%h we=%b, want 0 0 1 0 1", req_valid, o_word_count, o_idle, req_addr, req_we);
        end
        @(negedge clk_50);
        rst_n = 1;
        m_clear();
    endtask

    initial begin
        test_reset();
        test_seq_pack();
        test_simd_flush();
        test_backpressure();
        test_scatter_start();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/out_pixel_packer.md
OUT_PIXEL_PACKER -- requirements
Module: out_pixel_packer

Interface
REQ-001 Parameter AW, default 18, word-address width of output memory; pixel (byte) addresses on inputs are also AW bits.
REQ-002 Parameter OUT_BASE, default 0, word offset added to every emitted address.
REQ-003 Parameter FIFO_DEPTH, default 8, power of two ≥4, word FIFO entries.
REQ-004 clk_50  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_start  in  1  synchronous clear pulse, same pulse that starts the bilinear core.
REQ-007 i_mode_simd  in  1  1: lanes 0-3 active; 0: lane 0 only, lanes 1-3 ignored.
REQ-008 i_waddrK  in  AW  pixel byte address, lane K=0..3.
REQ-009 i_wdataK  in  8  pixel value, lane K.
REQ-010 i_weK  in  1  write strobe, lane K.
REQ-011 i_flush  in  1  pulse: emit partial buffered word.
REQ-012 req_valid / req_ready  out / in  1 / 1  write-request handshake to wide output memory.
REQ-013 req_we  out  1  constant 1.
REQ-014 req_addr  out  AW  word address = OUT_BASE + (pixel addr >> 2), truncated to AW.
REQ-015 req_wdata  out  32  4 pixels; byte lane b = addr[1:0] at bits 8b+7:8b.
REQ-016 req_be  out  4  byte enables of valid pixels.
REQ-017 o_idle  out  1  buffer empty, FIFO empty, no flush pending.
REQ-018 o_word_count  out  32  words accepted by memory (req_valid & req_ready).
REQ-019 o_err_overflow / o_err_scatter  out  1 / 1  sticky error flags.

Function
REQ-020 Group G per cycle = active lanes with we; A = word address of lowest-numbered active lane; lanes in word A or A+1 accepted, others dropped and set o_err_scatter.
REQ-021 Same byte written twice in one cycle: higher lane wins; byte rewritten in buffer: newer value overwrites.
REQ-022 Single word buffer (buf_valid, buf_addr, buf_data, buf_be); pushes to FIFO at the edge ending the cycle, in order below.
REQ-023 Push 1: buf_valid and buf_addr != A -> old buffer pushed first.
REQ-024 Push 2: G spans A and A+1 -> word A (merged with buffer if buf_addr==A) pushed; buffer becomes A+1 content.
REQ-025 G in word A only -> merged into buffer; if resulting be==4'hF it is pushed and buf_valid cleared.
REQ-026 At most 2 pushes per cycle; FIFO pop ≤1 per cycle; simultaneous push/pop allowed at any occupancy.
REQ-027 Push with insufficient free entries (after same-cycle pop): excess words dropped, o_err_overflow set.
REQ-028 i_flush with no writes: buffer (if valid) pushed with its partial be; with writes in same cycle: flush latched pending, executed on next write-free cycle.
REQ-029 req_valid = FIFO non-empty; req_addr/wdata/be from FIFO head; word pushed at edge N is visible from cycle N+1.
REQ-030 While req_valid & !req_ready, req_addr/wdata/be SHALL stay stable (except i_start/reset).
REQ-031 o_word_count increments by 1 per accepted handshake, wraps at 2^32.
REQ-032 i_start: buffer, FIFO, pending flush, counters, errors cleared at that edge; writes in the i_start cycle discarded; req_valid low next cycle.

Reset
REQ-033 rst_n low: req_valid=0, req_addr=0, req_wdata=0, req_be=0, o_idle=1, o_word_count=0, errors=0, buffer/FIFO empty, immediately and asynchronously.
REQ-034 req_we=1 during and after reset.

Verification
REQ-035 Seq, ready=1, lane0 writes addr 0..3 data 0x0A,0x14,0x1E,0x28 cycles 1-4 -> cycle 5 req_valid, addr OUT_BASE, wdata 0x281E140A, be 4'hF, word_count 1 after.
REQ-036 SIMD, lanes addr 6,7,8,9 data 1,2,3,4 one cycle, then i_flush -> word 1 (wdata 0x02010000, be 4'hC) then word 2 (0x00000403, be 4'h3).
REQ-037 req_ready=0 for 10 cycles while 9 full words pushed (depth 8) -> 8 held stable, o_err_overflow=1; release -> 8 handshakes in order.
REQ-038 SIMD lanes addr 0 and 12 same cycle -> lane at 12 dropped, o_err_scatter=1; i_start -> flag 0, o_idle=1.
REQ-039 rst_n low mid-transfer with req_valid=1 -> req_valid 0 asynchronously, o_word_count 0, o_idle 1.
